ccr_unit: RTL and testbench

Condition-code register (CCR) for the execute stage. It is the producer side of the jump-decision flag interface. It holds the Z/N/C flags and updates them from ALU results. When the jump-decision logic reports a taken conditional jump, it clears the flag that jump consumed. On interrupt entry it saves the flags to a shadow stack, and on return-from-interrupt it restores them.

---
 rtl/ccr_unit.sv | 155 +++++++++++++++
 tb/tb_ccr_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ccr_unit.sv
`default_nettype none
// ============================================================================
// Module   : ccr_unit
// Purpose  : Condition-code register (Z/N/C) for the execute stage. Merges
//            ALU flag results under a per-bit mask, clears the flag consumed
//            by a taken conditional jump, and optionally saves/restores the
//            flags on a LIFO shadow stack across interrupt entry and RTI.
// Config   : CCR_SHADOW_STACK_EN - when defined, a DEPTH-entry shadow stack
//            is built. When undefined, save/restore are ignored, no storage
//            is built and the stack status outputs are tied to their idle
//            values.
// Ports    : clk          rising-edge clock
//            reset        synchronous active-low reset
//            alu_flags    ALU flags {Z,N,C}
//            alu_mask     per-bit write enable for alu_flags
//            jmp_taken    a conditional jump was taken this cycle
//            jump_type    01 JZ, 00 JN, 10 JC, 11 none
//            save         push current flags (interrupt entry)
//            restore      pop flags into the CCR (RTI)
//            flags_out    registered flags {Z,N,C}
//            stack_count  number of valid stack entries
//            stack_empty  stack_count == 0
//            stack_full   stack_count == DEPTH
//            stk_err      sticky overflow/underflow/collision indicator
// Revision : 1.0 - initial release
// ============================================================================
module ccr_unit #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       alu_flags,
  input  logic [2:0]       alu_mask,
  input  logic             jmp_taken,
  input  logic [1:0]       jump_type,
  input  logic             save,
  input  logic             restore,
  output logic [2:0]       flags_out,
  output logic [PTR_W:0]   stack_count,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             stk_err
);

  localparam logic [1:0] JT_JN   = 2'b00;
  localparam logic [1:0] JT_JZ   = 2'b01;
  localparam logic [1:0] JT_JC   = 2'b10;

  logic [2:0] flags_q;
  logic [2:0] flags_d;
  logic [2:0] clr_mask;
  logic [2:0] flags_merged;

  // Bit the taken jump consumed; jump_type 11 consumes nothing.
  always_comb begin
    clr_mask = 3'b000;
    if (jmp_taken) begin
      case (jump_type)
        JT_JZ:   clr_mask = 3'b100;
        JT_JN:   clr_mask = 3'b010;
        JT_JC:   clr_mask = 3'b001;
        default: clr_mask = 3'b000;
      endcase
    end
  end

  // Clear first, then merge, so the ALU wins on a bit the jump also cleared.
  assign flags_merged = ((flags_q & ~clr_mask) & ~alu_mask) | (alu_flags & alu_mask);

`ifdef CCR_SHADOW_STACK_EN
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [2:0]       stack_q [DEPTH];
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  logic             err_q;
  logic             err_d;
  logic             empty_w;
  logic             full_w;
  logic             pop_ok;
  logic             push_ok;
  logic [PTR_W-1:0] top_idx;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == FULL_CNT);

  // Restore takes priority over save; a collision drops the push.
  assign pop_ok  = restore && !empty_w;
  assign push_ok = save && !restore && !full_w;

  // Only meaningful when the stack is non-empty (pop_ok gates its use).
  assign top_idx = count_q[PTR_W-1:0] - PTR_W'(1);

  always_comb begin
    flags_d = flags_merged;
    count_d = count_q;
    err_d   = err_q;
    if (pop_ok) begin
      flags_d = stack_q[top_idx];
      count_d = count_q - (PTR_W+1)'(1);
    end else if (push_ok) begin
      count_d = count_q + (PTR_W+1)'(1);
    end
    if ((save && restore) || (restore && empty_w) || (save && !restore && full_w)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Stack contents need no reset; the count alone defines validity.
  // Index is safe to truncate: push_ok is false once the count reaches DEPTH.
  always_ff @(posedge clk) begin
    if (reset && push_ok) begin
      stack_q[count_q[PTR_W-1:0]] <= flags_q;
    end
  end

  assign stack_count = count_q;
  assign stack_empty = empty_w;
  assign stack_full  = full_w;
  assign stk_err     = err_q;
`else
  logic unused_stack_ins;

  assign flags_d          = flags_merged;
  assign unused_stack_ins = ^{save, restore} ^ (DEPTH < 2);

  assign stack_count = '0;
  assign stack_empty = 1'b1;
  assign stack_full  = 1'b0;
  assign stk_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags_out = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_ccr_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccr_unit
// Purpose  : Self-checking bench for ccr_unit. A reference model computes the
//            expected state for each driven cycle and pushes it to a
//            scoreboard queue; the entry is popped and compared once the DUT
//            registers the cycle. Follows CCR_SHADOW_STACK_EN like the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ccr_unit;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
`ifdef CCR_SHADOW_STACK_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif

  logic           clk;
  logic           reset;
  logic [2:0]     alu_flags;
  logic [2:0]     alu_mask;
  logic           jmp_taken;
  logic [1:0]     jump_type;
  logic           save;
  logic           restore;
  logic [2:0]     flags_out;
  logic [PTR_W:0] stack_count;
  logic           stack_empty;
  logic           stack_full;
  logic           stk_err;

  ccr_unit #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_flags   (alu_flags),
    .alu_mask    (alu_mask),
    .jmp_taken   (jmp_taken),
    .jump_type   (jump_type),
    .save        (save),
    .restore     (restore),
    .flags_out   (flags_out),
    .stack_count (stack_count),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .stk_err     (stk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] flags;
    int         count;
    logic       err;
  } exp_t;

  exp_t       sb_q[$];
  logic [2:0] m_stack[$];
  logic [2:0] m_flags;
  logic       m_err;
  int         n_checks;
  int         n_pass;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model of one clock edge, straight from the flag/stack rules.
  task automatic model_step(input logic rst_n, input logic [2:0] af, input logic [2:0] am,
                            input logic jt, input logic [1:0] jty, input logic sv, input logic rs);
    logic [2:0] fc;
    logic [2:0] nf;
    int         sz;
    if (!rst_n) begin
      m_flags = 3'b000;
      m_err   = 1'b0;
      m_stack.delete();
      return;
    end
    sz = m_stack.size();
    if (STK_EN && rs && sz > 0) begin
      nf = m_stack[sz-1];
    end else begin
      fc = m_flags;
      if (jt) begin
        if (jty == 2'b01) fc[2] = 1'b0;
        if (jty == 2'b00) fc[1] = 1'b0;
        if (jty == 2'b10) fc[0] = 1'b0;
      end
      nf = (fc & ~am) | (af & am);
    end
    if (STK_EN) begin
      if (sv && rs) m_err = 1'b1;
      if (rs && sz == 0) m_err = 1'b1;
      if (sv && !rs && sz == DEPTH) m_err = 1'b1;
      if (rs && sz > 0) void'(m_stack.pop_back());
      else if (sv && !rs && sz < DEPTH) m_stack.push_back(m_flags);
    end
    m_flags = nf;
  endtask

  // Drive one cycle, score it, and compare after the edge.
  task automatic cyc(input logic rst_n, input logic [2:0] af, input logic [2:0] am,
                     input logic jt, input logic [1:0] jty, input logic sv, input logic rs);
    exp_t e;
    reset = rst_n; alu_flags = af; alu_mask = am;
    jmp_taken = jt; jump_type = jty; save = sv; restore = rs;
    model_step(rst_n, af, am, jt, jty, sv, rs);
    e.flags = m_flags; e.count = m_stack.size(); e.err = m_err;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("flags", 32'(flags_out), 32'(e.flags));
    chk("count", 32'(stack_count), 32'(e.count));
    chk("empty", 32'(stack_empty), 32'(e.count == 0));
    chk("full", 32'(stack_full), 32'(e.count == DEPTH));
    chk("err", 32'(stk_err), 32'(e.err));
  endtask

  task automatic alu(input logic [2:0] v);
    cyc(1'b1, v, 3'b111, 1'b0, 2'b11, 1'b0, 1'b0);
  endtask

  task automatic jmp(input logic [1:0] t);
    cyc(1'b1, 3'b000, 3'b000, 1'b1, t, 1'b0, 1'b0);
  endtask

  task automatic ss(input logic sv, input logic rs);
    cyc(1'b1, 3'b000, 3'b000, 1'b0, 2'b11, sv, rs);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_flags  = 3'b000;
    m_err    = 1'b0;
    reset = 1'b0; alu_flags = 3'b111; alu_mask = 3'b111;
    jmp_taken = 1'b0; jump_type = 2'b11; save = 1'b0; restore = 1'b0;

    // Reset dominates active inputs, then ALU update.
    cyc(1'b0, 3'b111, 3'b111, 1'b0, 2'b11, 1'b1, 1'b0);
    cyc(1'b0, 3'b111, 3'b111, 1'b0, 2'b11, 1'b0, 1'b0);
    chk("rst_flags", 32'(flags_out), 32'h0);
    alu(3'b101);
    chk("alu_101", 32'(flags_out), 32'h5);
    chk("alu_empty", 32'(stack_empty), 32'h1);

    // Jump clears: 111 -> JZ 011 -> JC 010 -> JN 000.
    alu(3'b111);
    jmp(2'b01); chk("jz_clr", 32'(flags_out), 32'h3);
    jmp(2'b10); chk("jc_clr", 32'(flags_out), 32'h2);
    jmp(2'b00); chk("jn_clr", 32'(flags_out), 32'h0);

    // No-jump type clears nothing.
    alu(3'b111);
    jmp(2'b11); chk("jnone", 32'(flags_out), 32'h7);

    // Clear and ALU on the same bit: ALU wins.
    alu(3'b100);
    cyc(1'b1, 3'b100, 3'b100, 1'b1, 2'b01, 1'b0, 1'b0);
    chk("alu_wins", 32'(flags_out), 32'h4);

    // Partial mask keeps unmasked bits.
    cyc(1'b1, 3'b011, 3'b001, 1'b0, 2'b11, 1'b0, 1'b0);
    chk("mask_part", 32'(flags_out), 32'h5);

    // Save/restore LIFO.
    alu(3'b001); ss(1'b1, 1'b0);
    alu(3'b110); ss(1'b1, 1'b0);
    alu(3'b000);
    ss(1'b0, 1'b1);
    chk("rti1", 32'(flags_out), STK_EN ? 32'h6 : 32'h0);
    ss(1'b0, 1'b1);
    chk("rti2", 32'(flags_out), STK_EN ? 32'h1 : 32'h0);
    chk("rti_cnt", 32'(stack_count), 32'h0);

    // Overflow, underflow, collision.
    for (int i = 0; i < 5; i++) begin
      alu(3'(i + 1));
      ss(1'b1, 1'b0);
    end
    chk("ovf_cnt", 32'(stack_count), STK_EN ? DEPTH : 0);
    chk("ovf_full", 32'(stack_full), 32'(STK_EN));
    chk("ovf_err", 32'(stk_err), 32'(STK_EN));
    for (int i = 0; i < DEPTH; i++) ss(1'b0, 1'b1);
    chk("pop_last", 32'(flags_out), STK_EN ? 32'h1 : 32'h5);
    cyc(1'b1, 3'b010, 3'b111, 1'b0, 2'b11, 1'b0, 1'b1);
    chk("udf_flags", 32'(flags_out), 32'h2);
    ss(1'b1, 1'b0);
    ss(1'b1, 1'b1);
    chk("coll_cnt", 32'(stack_count), 32'h0);
    chk("err_sticky", 32'(stk_err), 32'(STK_EN));

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 49) != 0),
          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    // Reset clears the sticky error.
    cyc(1'b0, 3'b000, 3'b000, 1'b0, 2'b11, 1'b0, 1'b0);
    chk("err_rst", 32'(stk_err), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
